// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned GRANT_W = 3;
  localparam logic [7:0]  HDR_TAG = 8'hA0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_LOAD    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus UART transmitter handshake shared by arbiter and environment.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [GRANT_W-1:0]   grant_id;
  logic                 active;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, active
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, active
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin winner search starting one past the last owner.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] win_o,
  output logic               valid_o
);

  int unsigned idx;
  logic        hit;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    hit     = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (j == idx) hit = req_i[j];
      end
      if (hit && !valid_o) begin
        valid_o = 1'b1;
        win_o   = GRANT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams, one message per grant.
// Define UART_ARB_HDR_EN to prefix every grant with header byte HDR_TAG | grant_id.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_MSG_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.master  bus
);

`ifdef UART_ARB_HDR_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] gid_q, owner_q;
  logic [7:0]         cnt_q, tx_data_q;
  logic               last_q, tx_start_q, active_q, hdr_q;

  logic [GRANT_W-1:0] win;
  logic               win_vld;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] ready_c;
  logic               grant, xfer, hdr_send, rel, done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (bus.req_valid),
    .last_i  (owner_q),
    .win_o   (win),
    .valid_o (win_vld)
  );

  // Owner's stream, muxed by grant index.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == GRANT_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign done = last_q || (cnt_q == 8'(MAX_MSG_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (|bus.req_valid) state_d = S_ARB;
      S_ARB:     state_d = win_vld ? S_LOAD : S_IDLE;
      S_LOAD:    if (!bus.tx_busy && (hdr_q || sel_valid)) state_d = S_WAIT_HI;
      S_WAIT_HI: if (bus.tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!bus.tx_busy) state_d = done ? S_IDLE : S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  // Only the owner is ever offered ready, and never while the header is pending.
  always_comb begin
    ready_c  = '0;
    grant    = 1'b0;
    xfer     = 1'b0;
    hdr_send = 1'b0;
    rel      = 1'b0;
    unique case (state_q)
      S_ARB:  grant = win_vld;
      S_LOAD: begin
        if (!bus.tx_busy) begin
          if (hdr_q) begin
            hdr_send = 1'b1;
          end else begin
            for (int i = 0; i < NUM_REQ; i++) ready_c[i] = (gid_q == GRANT_W'(i));
            xfer = sel_valid;
          end
        end
      end
      S_WAIT_LO: rel = !bus.tx_busy && done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gid_q      <= '0;
      owner_q    <= GRANT_W'(NUM_REQ - 1);
      cnt_q      <= 8'h00;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      hdr_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (grant) begin
        gid_q    <= win;
        owner_q  <= win;
        active_q <= 1'b1;
        cnt_q    <= 8'h00;
        last_q   <= 1'b0;
        hdr_q    <= HDR_EN;
      end
      if (hdr_send) begin
        tx_data_q  <= HDR_TAG | 8'(gid_q);
        tx_start_q <= 1'b1;
        hdr_q      <= 1'b0;
        last_q     <= 1'b0;
      end
      if (xfer) begin
        tx_data_q  <= sel_data;
        tx_start_q <= 1'b1;
        last_q     <= sel_last;
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      end
      if (rel) begin
        active_q <= 1'b0;
        gid_q    <= '0;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.grant_id  = gid_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester feeders and a simple UART busy model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned N = 4;
`ifdef UART_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_MSG_LEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [N-1:0]   rv = '0, rl = '0, pause = '0;
  logic [N*8-1:0] rd = '0;
  logic           busy = 1'b0;
  int             bcnt = 0;

  assign bus.req_valid = rv;
  assign bus.req_last  = rl;
  assign bus.req_data  = rd;
  assign bus.tx_busy   = busy;

  logic [7:0] qd[N][$];
  logic       ql[N][$];
  logic [7:0] log_b[$], exp_b[$];
  logic [2:0] log_g[$], exp_g[$];
  int total = 0, bad = 0, bad_start = 0;

  // Requester feeders: pop on accepted transfer, present next byte on falling edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (rv[i] && bus.req_ready[i] && qd[i].size() > 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0 && !pause[i]) begin
        rv[i] = 1'b1; rd[8*i +: 8] = qd[i][0]; rl[i] = ql[i][0];
      end else begin
        rv[i] = 1'b0; rd[8*i +: 8] = 8'h00; rl[i] = 1'b0;
      end
    end
  end

  // UART model: busy for three cycles after each start pulse.
  always @(negedge clk) begin
    if (bus.tx_start) begin
      if (busy) bad_start++;
      log_b.push_back(bus.tx_data);
      log_g.push_back(bus.grant_id);
      bcnt = 3;
    end
    busy = (bcnt != 0);
    if (bcnt != 0) bcnt--;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    qd[r].push_back(b);
    ql[r].push_back(l);
  endtask

  task automatic expect_byte(input int g, input logic [7:0] b, input bit first);
    if (first && HDR != 0) begin
      exp_b.push_back(HDR_TAG | 8'(g));
      exp_g.push_back(3'(g));
    end
    exp_b.push_back(b);
    exp_g.push_back(3'(g));
  endtask

  task automatic clear_logs();
    log_b.delete(); log_g.delete(); exp_b.delete(); exp_g.delete();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, log_b.size(), exp_b.size());
    for (int k = 0; k < exp_b.size(); k++)
      if (k < log_b.size()) begin
        chk($sformatf("%s_byte%0d", tag, k), {24'h0, log_b[k]}, {24'h0, exp_b[k]});
        chk($sformatf("%s_gid%0d", tag, k), {29'h0, log_g[k]}, {29'h0, exp_g[k]});
      end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int c = 0;
    while (log_b.size() < n && c < budget) begin tick(1); c++; end
    chk({tag, "_wait_log"}, 32'(log_b.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while ((bus.active || busy) && c < budget) begin tick(1); c++; end
    chk({tag, "_wait_idle"}, {31'h0, bus.active}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
    pause = '0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    clear_logs();
  endtask

  initial begin
    int nlog;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlog;
    // Reset values while rst_n held low
    tick(3);
    chk("rst_tx_start", {31'h0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
    chk("rst_req_ready", {28'h0, bus.req_ready}, 32'h0);
    chk("rst_grant_id", {29'h0, bus.grant_id}, 32'd0);
    chk("rst_active", {31'h0, bus.active}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single requester 1, two bytes, with latency checks
    push(1, 8'h55, 1'b0); push(1, 8'h3C, 1'b1);
    expect_byte(1, 8'h55, 1); expect_byte(1, 8'h3C, 0);
    tick(1);
    chk("lat_arb_active", {31'h0, bus.active}, 32'd0);
    tick(1);
    chk("lat_grant_active", {31'h0, bus.active}, 32'd1);
    chk("lat_grant_id", {29'h0, bus.grant_id}, 32'd1);
    chk("lat_ready", {28'h0, bus.req_ready}, (HDR != 0) ? 32'h0 : 32'h2);
    tick(1);
    chk("lat_tx_start", {31'h0, bus.tx_start}, 32'd1);
    chk("lat_tx_data", {24'h0, bus.tx_data}, (HDR != 0) ? 32'hA1 : 32'h55);
    chk("lat_ready_off", {28'h0, bus.req_ready}, 32'h0);
    tick(1);
    chk("lat_start_pulse", {31'h0, bus.tx_start}, 32'd0);
    wait_log(exp_b.size(), 200, "t1");
    wait_idle(200, "t1");
    check_log("t1");
    chk("t1_idle_gid", {29'h0, bus.grant_id}, 32'd0);

    // Round robin among 0, 2, 3 with continuous valid
    do_reset();
    push(0, 8'h10, 1'b1); push(2, 8'h20, 1'b1); push(3, 8'h30, 1'b1);
    push(0, 8'h11, 1'b1); push(2, 8'h21, 1'b1); push(3, 8'h31, 1'b1);
    expect_byte(0, 8'h10, 1); expect_byte(2, 8'h20, 1); expect_byte(3, 8'h30, 1);
    expect_byte(0, 8'h11, 1); expect_byte(2, 8'h21, 1); expect_byte(3, 8'h31, 1);
    wait_log(exp_b.size(), 600, "t2");
    wait_idle(200, "t2");
    check_log("t2");

    // Forced release after 64 bytes with requester 1 pending
    do_reset();
    for (int k = 0; k < 70; k++) push(0, 8'(k), 1'b0);
    push(1, 8'hEE, 1'b1);
    for (int k = 0; k < 64; k++) expect_byte(0, 8'(k), k == 0);
    expect_byte(1, 8'hEE, 1);
    for (int k = 64; k < 70; k++) expect_byte(0, 8'(k), k == 64);
    wait_log(exp_b.size(), 3000, "t3");
    tick(10);
    check_log("t3");
    chk("t3_hold_active", {31'h0, bus.active}, 32'd1);
    chk("t3_hold_gid", {29'h0, bus.grant_id}, 32'd0);

    // Owner stalls for 100 cycles mid-message
    do_reset();
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    expect_byte(2, 8'hA1, 1); expect_byte(2, 8'hA2, 0); expect_byte(2, 8'hA3, 0);
    wait_log(HDR + 1, 100, "t4");
    pause[2] = 1'b1;
    nlog = log_b.size();
    tick(100);
    chk("t4_no_start", log_b.size(), nlog);
    chk("t4_active", {31'h0, bus.active}, 32'd1);
    chk("t4_gid", {29'h0, bus.grant_id}, 32'd2);
    pause[2] = 1'b0;
    wait_log(exp_b.size(), 200, "t4");
    wait_idle(200, "t4");
    check_log("t4");

    // Header (when enabled) and back-to-back regrant of a lone requester
    clear_logs();
    push(2, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
    expect_byte(2, 8'h11, 1); expect_byte(2, 8'h12, 1);
    wait_log(exp_b.size(), 300, "t5");
    wait_idle(200, "t5");
    check_log("t5");

    // Reset during WAIT_LO abandons the message
    do_reset();
    push(3, 8'h77, 1'b0); push(3, 8'h78, 1'b1);
    wait_log(HDR + 1, 100, "t6");
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
    #1;
    chk("t6_rst_tx_start", {31'h0, bus.tx_start}, 32'd0);
    chk("t6_rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
    chk("t6_rst_ready", {28'h0, bus.req_ready}, 32'h0);
    chk("t6_rst_gid", {29'h0, bus.grant_id}, 32'd0);
    chk("t6_rst_active", {31'h0, bus.active}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    clear_logs();
    push(3, 8'h02, 1'b1); push(0, 8'h01, 1'b1);
    expect_byte(0, 8'h01, 1); expect_byte(3, 8'h02, 1);
    wait_log(exp_b.size(), 300, "t6");
    wait_idle(200, "t6");
    check_log("t6");

    chk("no_start_while_busy", bad_start, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter MAX_MSG_LEN, default 64, maximum data bytes sent per grant before forced release (legal 1..255).
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  marks final byte of requester's message.
REQ-009 req_ready  output  NUM_REQ  per-requester byte accept; transfer = valid & ready.
REQ-010 tx_data  output  8  byte to UART transmitter.
REQ-011 tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-012 tx_busy  input  1  UART transmitter busy flag.
REQ-013 grant_id  output  3  index of current owner; 0 when idle.
REQ-014 active  output  1  high while a grant is held.

Function
REQ-015 FSM states: IDLE, ARB, LOAD, WAIT_HI, WAIT_LO.
REQ-016 IDLE -> ARB when any req_valid is high; ARB registers a round-robin winner, starting the search at (last owner + 1) mod NUM_REQ, then -> LOAD.
REQ-017 In LOAD with tx_busy low, req_ready[grant_id] SHALL be high (combinational); all other req_ready bits SHALL be low in every state.
REQ-018 On transfer, the next edge SHALL load tx_data with the byte, pulse tx_start for exactly one cycle and enter WAIT_HI.
REQ-019 WAIT_HI -> WAIT_LO when tx_busy = 1; WAIT_LO -> next step when tx_busy = 0.
REQ-020 After WAIT_LO: if the sent byte had req_last, or the byte count equals MAX_MSG_LEN, release the grant -> IDLE; otherwise -> LOAD.
REQ-021 In LOAD, an owner with req_valid low SHALL keep the grant; no timeout applies.
REQ-022 Latency: req_valid rising in IDLE at cycle 0 -> grant at cycle 1 -> req_ready at cycle 2 -> tx_start at cycle 3.
REQ-023 The byte counter SHALL be 8 bits, cleared on grant, incremented per data byte, and never wrap.
REQ-024 Simultaneous requests in ARB SHALL be resolved strictly round-robin; a single requester SHALL be re-granted back-to-back.
REQ-025 tx_start SHALL never assert while tx_busy is high or while in WAIT_HI/WAIT_LO.

Reset
REQ-026 While rst_n is low: FSM = IDLE, tx_start = 0, tx_data = 0x00, req_ready = 0, grant_id = 0, active = 0, byte count = 0, and last owner = NUM_REQ-1 so that requester 0 wins first.
REQ-027 Reset asserted mid-message SHALL abandon the message; the byte held by the UART is not re-sent.

Configuration
REQ-028 With macro UART_ARB_HDR_EN defined, each grant SHALL first transmit header byte 0xA0 | grant_id via LOAD/WAIT states, with req_ready held low; the header does not count toward MAX_MSG_LEN.
REQ-029 Without UART_ARB_HDR_EN, there is no header byte and the first byte sent is the requester's data.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the FSM state enum, HDR_TAG = 8'hA0 and the grant_id width constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last owner; output: winner index and valid).

Verification
REQ-032 Single requester 1 sends 0x55, 0x3C (last) -> two tx_start pulses carrying 0x55 then 0x3C, active deasserts after the second busy fall, grant_id = 1.
REQ-033 Requesters 0, 2 and 3 hold valid continuously with 1-byte messages -> grant order 0, 2, 3, 0.
REQ-034 Requester 0 sends 70 bytes with no last and MAX_MSG_LEN = 64, with requester 1 pending -> after 64 bytes the grant passes to 1; requester 0's 65th byte follows later.
REQ-035 Owner drops req_valid for 100 cycles mid-message -> grant is held, no tx_start occurs, and the message resumes intact.
REQ-036 With UART_ARB_HDR_EN and requester 2 sending 0x11 (last) -> bytes 0xA2 then 0x11 are sent.
REQ-037 rst_n pulsed low during WAIT_LO -> all outputs read their reset values immediately, and the next grant goes to requester 0.
